// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: sequences PLL reset, deglitches lock, holds off and releases the system reset
module pll_lock_monitor #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned DEGLITCH       = 4,
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65536
) (
  input  logic       input_clk_25MHz,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       clear_count,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic       timeout_err,
  output logic [1:0] state
);
  typedef enum logic [1:0] {PLLRST, WAIT, HOLD, RUN} state_t;
  localparam int unsigned DW = $clog2(DEGLITCH + 1);
  localparam logic [DW-1:0] DG_LAST   = DW'(DEGLITCH - 1);
  localparam logic [31:0]   RST_LAST  = 32'(RST_CYCLES - 1);
  localparam logic [31:0]   HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);
  localparam logic [31:0]   TMO_LAST  = 32'(LOCK_TIMEOUT - 1);
  state_t cur, nxt;
  logic [1:0] sync_ff;
  logic sync_lock, stable_lock, loss, tmo;
  logic [DW-1:0] run_cnt;
  logic [31:0] cnt;
  assign sync_lock = sync_ff[1];
  assign state = cur;
  // two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge input_clk_25MHz or negedge reset_n)
    if (!reset_n) sync_ff <= '0;
    else sync_ff <= {sync_ff[0], locked};
  // lock is stable after DEGLITCH consecutive high samples; any low sample restarts the run
  always_ff @(posedge input_clk_25MHz or negedge reset_n)
    if (!reset_n) begin
      run_cnt <= '0;
      stable_lock <= 1'b0;
    end else if (!sync_lock) begin
      run_cnt <= '0;
      stable_lock <= 1'b0;
    end else if (run_cnt == DG_LAST) stable_lock <= 1'b1;
    else run_cnt <= run_cnt + 1'b1;
  // next-state decode; the timer counts edges since entering the current state
  always_comb begin
    nxt = cur;
    loss = 1'b0;
    tmo = 1'b0;
    case (cur)
      PLLRST: nxt = (cnt == RST_LAST) ? WAIT : PLLRST;
      WAIT: begin
        nxt = stable_lock ? HOLD : (cnt == TMO_LAST) ? PLLRST : WAIT;
        tmo = !stable_lock && cnt == TMO_LAST;
      end
      HOLD: nxt = !sync_lock ? WAIT : (cnt == HOLD_LAST) ? RUN : HOLD;
      RUN: begin
        nxt = sync_lock ? RUN : PLLRST;
        loss = !sync_lock;
      end
      default: nxt = PLLRST;
    endcase
  end
  // state, timer and registered outputs decoded from the next state
  always_ff @(posedge input_clk_25MHz or negedge reset_n)
    if (!reset_n) begin
      cur <= PLLRST;
      cnt <= '0;
      pll_rst <= 1'b1;
      sys_rst_n <= 1'b0;
      ready <= 1'b0;
      lock_loss_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      cur <= nxt;
      cnt <= (nxt != cur || cur == RUN) ? '0 : cnt + 32'd1;
      pll_rst <= nxt == PLLRST;
      sys_rst_n <= nxt == RUN;
      ready <= nxt == RUN;
      lock_loss_count <= clear_count ? '0 : (loss && lock_loss_count != 8'hFF) ? lock_loss_count + 8'd1 : lock_loss_count;
      timeout_err <= !clear_count && (timeout_err || tmo);
    end
endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: randomized and directed checks against a lookback-window reference model
module tb_pll_lock_monitor;
  localparam int RST = 4, DG = 3, HO = 8, TMO = 32;
  logic clk = 1'b0, reset_n, locked, clear_count;
  logic pll_rst, sys_rst_n, ready, timeout_err;
  logic [7:0] lock_loss_count;
  logic [1:0] state;
  int errs = 0, checks = 0;
  bit hist[$];
  int ms, entry, mcnt;
  bit mterr;

  pll_lock_monitor #(.RST_CYCLES(RST), .DEGLITCH(DG), .HOLDOFF_CYCLES(HO), .LOCK_TIMEOUT(TMO)) dut (
    .input_clk_25MHz(clk), .reset_n(reset_n), .locked(locked), .clear_count(clear_count),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .lock_loss_count(lock_loss_count),
    .timeout_err(timeout_err), .state(state));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit h(int k);
    return (k >= 1 && k <= hist.size()) ? hist[k-1] : 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    ms = 0; entry = 0; mcnt = 0; mterr = 0;
  endtask

  // locked sampled at edge k reaches the logic as sync_lock at edge k+2;
  // the lock counts as stable at edge t when the DG synchronized samples before it were all high
  task automatic model_step(input bit lk, input bit cl);
    int t, age, ns;
    bit sl, st, loss, tmo;
    hist.push_back(lk);
    t = hist.size();
    sl = h(t - 2);
    st = 1;
    for (int k = t - DG - 2; k <= t - 3; k++) st &= h(k);
    age = t - entry;
    ns = ms; loss = 0; tmo = 0;
    if (ms == 0 && age == RST) ns = 1;
    else if (ms == 1 && st) ns = 2;
    else if (ms == 1 && age == TMO) begin ns = 0; tmo = 1; end
    else if (ms == 2 && !sl) ns = 1;
    else if (ms == 2 && age == HO) ns = 3;
    else if (ms == 3 && !sl) begin ns = 0; loss = 1; end
    if (ns != ms) entry = t;
    ms = ns;
    if (cl) begin mcnt = 0; mterr = 0; end
    else begin
      if (loss && mcnt < 255) mcnt++;
      if (tmo) mterr = 1;
    end
  endtask

  task automatic check_all();
    check("state", state, ms);
    check("pll_rst", pll_rst, ms == 0);
    check("sys_rst_n", sys_rst_n, ms == 3);
    check("ready", ready, ms == 3);
    check("lock_loss_count", lock_loss_count, mcnt);
    check("timeout_err", timeout_err, mterr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(locked, clear_count);
    #1;
    check_all();
  endtask

  task automatic bring_up();
    locked = 1'b1;
    for (int i = 0; i < 200 && !ready; i++) tick();
    check("bring_up_ready", ready, 1);
  endtask

  task automatic lose_lock();
    locked = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset_n = 1'b0; locked = 1'b0; clear_count = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst_n", sys_rst_n, 0);
    check("rst_count", lock_loss_count, 0);
    model_reset();
    reset_n = 1'b1;
    repeat (3) tick();
    check("pllrst_len_hi", pll_rst, 1);
    tick();
    check("pllrst_len_lo", pll_rst, 0);
    check("enter_wait", state, 1);
    locked = 1'b1;
    repeat (2) tick();
    locked = 1'b0;
    repeat (10) tick();
    check("glitch_state", state, 1);
    check("glitch_sys_rst_n", sys_rst_n, 0);
    check("glitch_count", lock_loss_count, 0);
    locked = 1'b1;
    repeat (13) tick();
    check("bringup_early", ready, 0);
    tick();
    check("bringup_ready", ready, 1);
    check("bringup_state", state, 3);
    locked = 1'b0;
    repeat (2) tick();
    check("loss_early", sys_rst_n, 1);
    tick();
    check("loss_sys_rst_n", sys_rst_n, 0);
    check("loss_pll_rst", pll_rst, 1);
    check("loss_count", lock_loss_count, 1);
    repeat (4 + 31) tick();
    check("tmo_early_state", state, 1);
    check("tmo_early_err", timeout_err, 0);
    tick();
    check("tmo_state", state, 0);
    check("tmo_err", timeout_err, 1);
    bring_up();
    check("tmo_sticky", timeout_err, 1);
    for (int s = 0; s < 40; s++) begin
      locked = $urandom_range(0, 1);
      repeat ($urandom_range(1, 60)) begin
        clear_count = ($urandom_range(0, 15) == 0);
        tick();
      end
      clear_count = 1'b0;
    end
    repeat (260) begin
      bring_up();
      lose_lock();
    end
    check("sat_count", lock_loss_count, 255);
    bring_up();
    locked = 1'b0;
    repeat (2) tick();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check("clear_count", lock_loss_count, 0);
    check("clear_err", timeout_err, 0);
    check("clear_loss_state", state, 0);
    bring_up();
    lose_lock();
    bring_up();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_sys_rst_n", sys_rst_n, 0);
    check("async_pll_rst", pll_rst, 1);
    check("async_ready", ready, 0);
    check("async_count", lock_loss_count, 0);
    check("async_state", state, 0);
    model_reset();
    #1 reset_n = 1'b1;
    repeat (30) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of cycles pll_rst is held high per PLL reset pulse.
REQ-002 SHALL have parameter DEGLITCH, default 4: number of consecutive synchronized-high samples of locked required to declare the lock stable.
REQ-003 SHALL have parameter HOLDOFF_CYCLES, default 1024: number of cycles between a stable lock and release of sys_rst_n.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 65536: maximum number of cycles to wait for a stable lock before re-resetting the PLL.
REQ-005 SHALL have input_clk_25MHz, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have locked, input, 1 bit: PLL lock indication, asynchronous to input_clk_25MHz.
REQ-008 SHALL have clear_count, input, 1 bit: synchronous clear of lock_loss_count and timeout_err.
REQ-009 SHALL have pll_rst, output, 1 bit: active-high reset to the PLL.
REQ-010 SHALL have sys_rst_n, output, 1 bit: active-low reset to downstream logic.
REQ-011 SHALL have ready, output, 1 bit: high only in RUN.
REQ-012 SHALL have lock_loss_count, output, 8 bits: saturating count of lock losses in RUN.
REQ-013 SHALL have timeout_err, output, 1 bit: sticky lock-timeout flag.
REQ-014 SHALL have state, output, 2 bits: PLLRST=0, WAIT=1, HOLD=2, RUN=3.

Function
REQ-015 SHALL pass locked through a 2-flop synchronizer; all logic SHALL use only the synchronizer output (sync_lock).
REQ-016 SHALL register stable_lock: set once sync_lock has been 1 for DEGLITCH consecutive edges; cleared, with the run counter zeroed, on any edge at which sync_lock=0.
REQ-017 PLLRST SHALL drive pll_rst=1 for exactly RST_CYCLES cycles from entry, then go to WAIT.
REQ-018 WAIT SHALL drive pll_rst=0, clear the timeout counter on entry, and go to HOLD on the edge at which stable_lock=1 is sampled.
REQ-019 WAIT SHALL go to PLLRST and set timeout_err=1 after LOCK_TIMEOUT cycles without stable_lock; if stable_lock and timeout coincide, HOLD SHALL win.
REQ-020 HOLD SHALL count HOLDOFF_CYCLES cycles and then go to RUN; a sync_lock=0 in HOLD SHALL return to WAIT without incrementing lock_loss_count.
REQ-021 RUN SHALL assert sys_rst_n=1 and ready=1; on a sync_lock=0 it SHALL go to PLLRST and increment lock_loss_count.
REQ-022 SHALL register all outputs and drive them from next-state, so they change on the same edge as the state transition.
REQ-023 Bring-up latency: with T0 the first edge sampling locked=1 in WAIT, and locked held high, sys_rst_n and ready SHALL rise on edge T0+DEGLITCH+HOLDOFF_CYCLES+2.
REQ-024 Loss latency: with T1 the first edge sampling locked=0 in RUN, sys_rst_n=0, ready=0 and pll_rst=1 SHALL take effect on edge T1+2.
REQ-025 lock_loss_count SHALL saturate at 255.
REQ-026 clear_count=1 SHALL zero lock_loss_count and timeout_err on the next edge; a simultaneous increment SHALL be discarded (result 0).
REQ-027 timeout_err SHALL remain set through later successful locks until clear_count or reset.

Reset
REQ-028 reset_n=0 SHALL immediately (asynchronously) force state=PLLRST, pll_rst=1, sys_rst_n=0, ready=0, lock_loss_count=0, timeout_err=0, and zero all counters and synchronizer flops.
REQ-029 After reset_n rises, PLLRST SHALL begin its full RST_CYCLES count on the first edge.

Verification (RST_CYCLES=4, DEGLITCH=3, HOLDOFF_CYCLES=8, LOCK_TIMEOUT=32)
REQ-030 Bring-up: release reset, raise locked in WAIT at T0 -> pll_rst high exactly 4 cycles; sys_rst_n=1, ready=1, state=3 on edge T0+13.
REQ-031 Glitch: in WAIT, locked high 2 cycles then low -> state stays 1, sys_rst_n=0, count=0.
REQ-032 Loss: drop locked in RUN at T1 -> at edge T1+2 sys_rst_n=0, pll_rst=1 for 4 cycles, lock_loss_count=1.
REQ-033 Timeout: locked held 0 -> after 32 WAIT cycles timeout_err=1, state=0, pll_rst=1; a later good lock leaves timeout_err=1.
REQ-034 Saturation/clear: 256 RUN losses -> count=255; clear_count coincident with a loss -> count=0, timeout_err=0.
REQ-035 Async reset mid-RUN: reset_n=0 between edges -> sys_rst_n=0, pll_rst=1, ready=0, count=0 before the next edge.
